jpeg_bitstream_packer: RTL and testbench

//  Packs variable-length Huffman/amplitude codes from the entropy encoder into a

---
 rtl/jpeg_bitstream_packer_if.sv | 24 ++
 rtl/jpeg_bitstream_packer.sv | 136 +++++++++++++
 tb/tb_jpeg_bitstream_packer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/jpeg_bitstream_packer_if.sv
// Code-input, frame-control and byte-stream bundle of the JPEG bitstream packer.
// master = entropy-encoder/consumer side, slave = packer.
interface jpeg_bitstream_packer_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned LEN_W  = 6
);
   logic              bs_load_i;
   logic [DATA_W-1:0] bs_data_in_i;
   logic [LEN_W-1:0]  bs_data_len_i;
   logic              ee_frame_ready_i;
   logic              bs_frame_ready;
   logic              data_valid;
   logic [7:0]        data_out;

   modport master (
      output bs_load_i, bs_data_in_i, bs_data_len_i, ee_frame_ready_i,
      input  bs_frame_ready, data_valid, data_out
   );

   modport slave (
      input  bs_load_i, bs_data_in_i, bs_data_len_i, ee_frame_ready_i,
      output bs_frame_ready, data_valid, data_out
   );
endinterface

// File: rtl/jpeg_bitstream_packer.sv
// Packs right-aligned variable-length codes MSB-first into a JPEG byte stream,
// inserting 0x00 after every 0xFF and 1-padding the last byte at frame end.
module jpeg_bitstream_packer #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned LEN_W   = 6,
   parameter int unsigned FIFO_AW = 4
) (
   input  logic                   clk,
   input  logic                   rstn,
   jpeg_bitstream_packer_if.slave bs
);
   localparam int unsigned ACC_W  = 64;
   localparam int unsigned CNT_W  = 7;
   localparam int unsigned DEPTH  = 1 << FIFO_AW;
   localparam int unsigned FCNT_W = FIFO_AW + 1;
   localparam int unsigned FR_W   = FCNT_W + 1;
   localparam int unsigned MAXB   = 4;
   localparam int unsigned NB_W   = 3;

   typedef enum logic {S_RUN, S_FLUSH} state_t;

   state_t               state_q, state_d;
   logic [ACC_W-1:0]     acc_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [7:0]           fifo_mem [DEPTH];
   logic [FIFO_AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [FCNT_W-1:0]    fifo_cnt_q;
   logic                 stuff_q;
   logic                 valid_q;
   logic [7:0]           dout_q;
   logic                 frame_ready_q, frame_ready_d;

   logic                 load_en_c;
   logic [LEN_W-1:0]     len_c;
   logic [CNT_W-1:0]     sh_c;
   logic [ACC_W-1:0]     code_c, aligned_c, pad_c, full_c;
   logic [CNT_W-1:0]     merged_cnt_c, padded_cnt_c, out_cnt_c;
   logic [NB_W-1:0]      nbytes_c, nwr_c;
   logic [FR_W-1:0]      free_c;
   logic                 pop_c, ovf_c;

   // Append the new code behind the buffered bits, pad with 1s when flushing,
   // and count the complete bytes ready to move into the FIFO.
   always_comb begin
      load_en_c    = bs.bs_load_i && (bs.bs_data_len_i != '0);
      len_c        = load_en_c ? bs.bs_data_len_i : '0;
      sh_c         = CNT_W'(ACC_W) - CNT_W'(len_c);
      code_c       = ACC_W'(bs.bs_data_in_i) & ~({ACC_W{1'b1}} << len_c);
      aligned_c    = (code_c << sh_c) >> cnt_q;
      merged_cnt_c = cnt_q + CNT_W'(len_c);
      padded_cnt_c = (merged_cnt_c + CNT_W'(7)) & ~CNT_W'(7);
      pad_c        = '0;
      out_cnt_c    = merged_cnt_c;
      if (state_q == S_FLUSH) begin
         pad_c     = ({ACC_W{1'b1}} >> merged_cnt_c) & ~({ACC_W{1'b1}} >> padded_cnt_c);
         out_cnt_c = padded_cnt_c;
      end
      full_c   = acc_q | aligned_c | pad_c;
      nbytes_c = NB_W'(out_cnt_c >> 3);
      pop_c    = !stuff_q && (fifo_cnt_q != '0);
      free_c   = FR_W'(DEPTH) - FR_W'(fifo_cnt_q) + FR_W'(pop_c);
      ovf_c    = FR_W'(nbytes_c) > free_c;
      nwr_c    = ovf_c ? NB_W'(free_c) : nbytes_c;
   end

   // Frame-end sequencing: wait until every buffered bit has left data_out.
   always_comb begin
      state_d       = state_q;
      frame_ready_d = 1'b0;
      case (state_q)
         S_RUN: begin
            if (bs.ee_frame_ready_i) state_d = S_FLUSH;
         end
         S_FLUSH: begin
            if ((cnt_q == '0) && (fifo_cnt_q == '0) && !stuff_q) begin
               state_d       = S_RUN;
               frame_ready_d = 1'b1;
            end
         end
         default: state_d = S_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= S_RUN;
         acc_q         <= '0;
         cnt_q         <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         fifo_cnt_q    <= '0;
         stuff_q       <= 1'b0;
         valid_q       <= 1'b0;
         dout_q        <= '0;
         frame_ready_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         frame_ready_q <= frame_ready_d;
         acc_q         <= full_c << {nbytes_c, 3'b000};
         cnt_q         <= out_cnt_c - CNT_W'({nbytes_c, 3'b000});
         wr_ptr_q      <= wr_ptr_q + FIFO_AW'(nwr_c);
         fifo_cnt_q    <= fifo_cnt_q + FCNT_W'(nwr_c) - FCNT_W'(pop_c);
         if (pop_c) rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
         // A stuffed 0x00 takes the output slot without popping the FIFO.
         if (stuff_q) begin
            valid_q <= 1'b1;
            dout_q  <= 8'h00;
            stuff_q <= 1'b0;
         end else if (pop_c) begin
            valid_q <= 1'b1;
            dout_q  <= fifo_mem[rd_ptr_q];
            stuff_q <= (fifo_mem[rd_ptr_q] == 8'hFF);
         end else begin
            valid_q <= 1'b0;
         end
      end
   end

   // Byte storage; bytes that do not fit are dropped.
   always_ff @(posedge clk) begin
      for (int i = 0; i < MAXB; i++) begin
         if (NB_W'(i) < nwr_c)
            fifo_mem[wr_ptr_q + FIFO_AW'(i)] <= full_c[ACC_W-1-8*i -: 8];
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (rstn && ovf_c) $error("jpeg_bitstream_packer: byte FIFO overflow, bytes dropped");
   end
`endif

   assign bs.bs_frame_ready = frame_ready_q;
   assign bs.data_valid     = valid_q;
   assign bs.data_out       = dout_q;
endmodule

// File: tb/tb_jpeg_bitstream_packer.sv
// Directed bench for jpeg_bitstream_packer: frame table plus latency,
// no-flush and mid-stream reset sequences.
module tb_jpeg_bitstream_packer;
   typedef struct packed {
      int               n_codes;
      logic [2:0][31:0] code;
      logic [2:0][5:0]  len;
      logic             ee_same;
      int               n_exp;
      logic [63:0]      exp;
   } vec_t;

   localparam int NV = 10;

   logic ee_clk;
   logic rstn;
   int   cyc;
   int   n_tests;
   int   n_fail;

   jpeg_bitstream_packer_if #(.DATA_W(32), .LEN_W(6)) bs_if ();

   jpeg_bitstream_packer #(.DATA_W(32), .LEN_W(6), .FIFO_AW(4)) dut (
      .clk  (ee_clk),
      .rstn (rstn),
      .bs   (bs_if)
   );

   initial begin
      ee_clk = 1'b0;
      forever #5 ee_clk = ~ee_clk;
   end

   initial cyc = 0;
   always @(posedge ee_clk) cyc <= cyc + 1;

   logic [7:0] got_q[$];
   int         cyc_q[$];
   int         last_valid_cyc;
   int         fr_cnt;
   int         fr_cyc;

   initial begin
      fr_cnt = 0;
      fr_cyc = -1;
      last_valid_cyc = -1;
   end

   always @(negedge ee_clk) begin
      if (bs_if.data_valid === 1'b1) begin
         got_q.push_back(bs_if.data_out);
         cyc_q.push_back(cyc);
         last_valid_cyc = cyc;
      end
      if (bs_if.bs_frame_ready === 1'b1) begin
         fr_cnt = fr_cnt + 1;
         fr_cyc = cyc;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic idle_inputs();
      bs_if.bs_load_i        = 1'b0;
      bs_if.bs_data_in_i     = '0;
      bs_if.bs_data_len_i    = '0;
      bs_if.ee_frame_ready_i = 1'b0;
   endtask

   task automatic send(input logic [31:0] code, input logic [5:0] len, input logic ee);
      bs_if.bs_load_i        = 1'b1;
      bs_if.bs_data_in_i     = code;
      bs_if.bs_data_len_i    = len;
      bs_if.ee_frame_ready_i = ee;
      @(posedge ee_clk); #1;
      idle_inputs();
   endtask

   task automatic wait_frame(input int fr0, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(posedge ee_clk); #1;
         if (fr_cnt != fr0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   function automatic vec_t mk(input int n,
                               input logic [31:0] c0, input logic [5:0] l0,
                               input logic [31:0] c1, input logic [5:0] l1,
                               input logic [31:0] c2, input logic [5:0] l2,
                               input logic same, input int ne, input logic [63:0] ex);
      vec_t v;
      v.n_codes = n;
      v.code    = {c2, c1, c0};
      v.len     = {l2, l1, l0};
      v.ee_same = same;
      v.n_exp   = ne;
      v.exp     = ex;
      return v;
   endfunction

   vec_t        vecs [NV];
   logic [63:0] e;
   bit          ok;
   int          fr0;
   int          ee_cyc;
   int          ld_cyc;
   int          nb;

   initial begin
      n_tests = 0;
      n_fail  = 0;
      // codes listed in order; expected bytes left-aligned, first byte in the top octet
      vecs[0] = mk(2, 32'h5, 6'd3, 32'h1A, 6'd5, 32'h0, 6'd0, 1'b0, 1, 64'hBA00_0000_0000_0000);
      vecs[1] = mk(1, 32'h3, 6'd2, 32'h0, 6'd0, 32'h0, 6'd0, 1'b0, 2, 64'hFF00_0000_0000_0000);
      vecs[2] = mk(1, 32'h07FF_FFFF, 6'd27, 32'h0, 6'd0, 32'h0, 6'd0, 1'b1, 8, 64'hFF00_FF00_FF00_FF00);
      vecs[3] = mk(0, 32'h0, 6'd0, 32'h0, 6'd0, 32'h0, 6'd0, 1'b0, 0, 64'h0);
      vecs[4] = mk(1, 32'hFFFF_FFF5, 6'd4, 32'h0, 6'd0, 32'h0, 6'd0, 1'b1, 1, 64'h5F00_0000_0000_0000);
      vecs[5] = mk(2, 32'hABCD, 6'd16, 32'h3, 6'd2, 32'h0, 6'd0, 1'b1, 4, 64'hABCD_FF00_0000_0000);
      vecs[6] = mk(2, 32'h1234_5678, 6'd32, 32'hFF, 6'd0, 32'h0, 6'd0, 1'b0, 4, 64'h1234_5678_0000_0000);
      vecs[7] = mk(3, 32'h7F, 6'd7, 32'h1, 6'd1, 32'h80, 6'd8, 1'b0, 3, 64'hFF00_8000_0000_0000);
      vecs[8] = mk(1, 32'h0, 6'd4, 32'h0, 6'd0, 32'h0, 6'd0, 1'b0, 1, 64'h0F00_0000_0000_0000);
      vecs[9] = mk(3, 32'h1, 6'd1, 32'h2, 6'd3, 32'h5, 6'd5, 1'b0, 3, 64'hA2FF_0000_0000_0000);

      rstn = 1'b0;
      idle_inputs();
      repeat (3) @(posedge ee_clk);
      #1;
      check("reset_data_valid", 32'(bs_if.data_valid), 32'd0);
      check("reset_frame_ready", 32'(bs_if.bs_frame_ready), 32'd0);
      check("reset_data_out", 32'(bs_if.data_out), 32'd0);
      rstn = 1'b1;
      repeat (3) @(posedge ee_clk);
      #1;
      check("idle_no_bytes", 32'(got_q.size()), 32'd0);
      check("idle_no_frame_ready", 32'(fr_cnt), 32'd0);

      // Two codes forming one byte, no frame end.
      got_q.delete(); cyc_q.delete(); fr0 = fr_cnt;
      send(32'h5, 6'd3, 1'b0);
      send(32'h1A, 6'd5, 1'b0);
      repeat (6) @(posedge ee_clk);
      #1;
      check("noflush_count", 32'(got_q.size()), 32'd1);
      if (got_q.size() > 0) check("noflush_byte", 32'(got_q[0]), 32'hBA);
      check("noflush_no_frame_ready", 32'(fr_cnt - fr0), 32'd0);

      // Stuffing and minimum latency: bytes on three consecutive cycles.
      got_q.delete(); cyc_q.delete();
      ld_cyc = cyc;
      send(32'hFF, 6'd8, 1'b0);
      send(32'h12, 6'd8, 1'b0);
      repeat (6) @(posedge ee_clk);
      #1;
      check("stuff_count", 32'(got_q.size()), 32'd3);
      if (got_q.size() == 3) begin
         check("stuff_b0", 32'(got_q[0]), 32'hFF);
         check("stuff_b1", 32'(got_q[1]), 32'h00);
         check("stuff_b2", 32'(got_q[2]), 32'h12);
         check("latency_b0", 32'(cyc_q[0] - ld_cyc), 32'd2);
         check("latency_b1", 32'(cyc_q[1] - ld_cyc), 32'd3);
         check("latency_b2", 32'(cyc_q[2] - ld_cyc), 32'd4);
      end

      // Frame table.
      for (int v = 0; v < NV; v++) begin
         got_q.delete(); cyc_q.delete();
         fr0 = fr_cnt;
         ee_cyc = -1;
         for (int k = 0; k < vecs[v].n_codes; k++) begin
            if (vecs[v].ee_same && (k == vecs[v].n_codes - 1)) ee_cyc = cyc;
            send(vecs[v].code[k], vecs[v].len[k], vecs[v].ee_same && (k == vecs[v].n_codes - 1));
         end
         if (!vecs[v].ee_same || (vecs[v].n_codes == 0)) begin
            bs_if.ee_frame_ready_i = 1'b1;
            ee_cyc = cyc;
            @(posedge ee_clk); #1;
            idle_inputs();
         end
         wait_frame(fr0, ok);
         check($sformatf("v%0d_frame_ready_seen", v), 32'(ok), 32'd1);
         repeat (4) @(posedge ee_clk);
         #1;
         check($sformatf("v%0d_frame_ready_pulses", v), 32'(fr_cnt - fr0), 32'd1);
         nb = got_q.size();
         check($sformatf("v%0d_byte_count", v), 32'(nb), 32'(vecs[v].n_exp));
         e = vecs[v].exp;
         for (int i = 0; i < vecs[v].n_exp && i < nb; i++)
            check($sformatf("v%0d_byte%0d", v, i), 32'(got_q[i]), 32'(e[63-8*i -: 8]));
         if (vecs[v].n_exp > 0)
            check($sformatf("v%0d_ready_after_last", v), 32'(fr_cyc - last_valid_cyc), 32'd1);
         else
            check($sformatf("v%0d_ready_delay", v), 32'(fr_cyc - ee_cyc), 32'd2);
      end

      // Reset with bytes queued and partial bits buffered.
      got_q.delete(); cyc_q.delete();
      send(32'h07FF_FFFF, 6'd27, 1'b0);
      send(32'h00AB_CDEF, 6'd24, 1'b0);
      send(32'h7, 6'd3, 1'b0);
      rstn = 1'b0;
      #1;
      check("midreset_valid_low", 32'(bs_if.data_valid), 32'd0);
      repeat (2) @(posedge ee_clk);
      #1;
      rstn = 1'b1;
      got_q.delete(); cyc_q.delete();
      fr0 = fr_cnt;
      repeat (8) @(posedge ee_clk);
      #1;
      check("midreset_no_stale", 32'(got_q.size()), 32'd0);
      send(32'h5, 6'd3, 1'b0);
      send(32'h1A, 6'd5, 1'b1);
      wait_frame(fr0, ok);
      check("postreset_frame_ready_seen", 32'(ok), 32'd1);
      check("postreset_count", 32'(got_q.size()), 32'd1);
      if (got_q.size() > 0) check("postreset_byte", 32'(got_q[0]), 32'hBA);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
